// File: rtl/simd_pkg.sv
// Shared SIMD operand-path types and defaults.
// Used by the broadcast stage and its bus interface.
package simd_pkg;

  localparam int DEF_PE_COUNT   = 4;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_REP_W      = 4;

  localparam int IDX_W = $clog2(DEF_PE_COUNT);

  typedef logic signed
    [DEF_PE_COUNT-1:0][DEF_DATA_WIDTH-1:0] vec_t;

  typedef enum logic {
    IDLE,
    STREAM
  } bcast_state_e;

endpackage

// File: rtl/vec_broadcast_if.sv
// Vector load / broadcast beat bus.
// slave = broadcast block, master = producer/consumer side.
interface vec_broadcast_if
  import simd_pkg::*;
#(
  parameter int PE_COUNT   = DEF_PE_COUNT,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int REP_W      = DEF_REP_W
);

  localparam int IW = $clog2(PE_COUNT);

  logic signed [PE_COUNT-1:0][DATA_WIDTH-1:0] vec_in;
  logic                                       vec_valid;
  logic                                       vec_ready;
  logic [REP_W-1:0]                           reps;
  logic                                       flush;
  logic signed [PE_COUNT-1:0][DATA_WIDTH-1:0] bcast_out;
  logic                                       bcast_valid;
  logic                                       bcast_ready;
  logic [IW-1:0]                              bcast_idx;
  logic                                       bcast_first;
  logic                                       bcast_last;
  logic                                       busy;

  modport slave (
    input  vec_in,
    input  vec_valid,
    input  reps,
    input  flush,
    input  bcast_ready,
    output vec_ready,
    output bcast_out,
    output bcast_valid,
    output bcast_idx,
    output bcast_first,
    output bcast_last,
    output busy
  );

  modport master (
    output vec_in,
    output vec_valid,
    output reps,
    output flush,
    output bcast_ready,
    input  vec_ready,
    input  bcast_out,
    input  bcast_valid,
    input  bcast_idx,
    input  bcast_first,
    input  bcast_last,
    input  busy
  );

endinterface

// File: rtl/vec_broadcast.sv
// Latches one PE vector and streams element[idx] replicated on
// every lane, each element repeated reps+1 times.
module vec_broadcast
  import simd_pkg::*;
#(
  parameter int PE_COUNT   = DEF_PE_COUNT,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int REP_W      = DEF_REP_W
) (
  input  logic           clk,
  input  logic           rstn,
  vec_broadcast_if.slave bus
);

  localparam int IW = $clog2(PE_COUNT);
  localparam logic [IW-1:0] IDX_MAX = IW'(PE_COUNT - 1);

  typedef logic signed
    [PE_COUNT-1:0][DATA_WIDTH-1:0] lvec_t;

  bcast_state_e     state_q;
  bcast_state_e     state_d;
  lvec_t            vec_q;
  logic [REP_W-1:0] reps_q;
  logic [REP_W-1:0] rep_q;
  logic [IW-1:0]    idx_q;

  lvec_t            out_q;
  logic             valid_q;
  logic             first_q;
  logic             last_q;
  logic             busy_q;

  logic             load;
  logic             hs;
  logic             abort;
  logic             done;
  logic             step_rep;
  logic [IW-1:0]    idx_nx;

  always_comb begin
    load     = bus.vec_valid && !busy_q;
    hs       = valid_q && bus.bcast_ready;
    abort    = (state_q == STREAM) && bus.flush;
    done     = hs && last_q && !abort;
    step_rep = rep_q < reps_q;
    idx_nx   = idx_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (load) state_d = STREAM;
      STREAM:  if (abort || done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vec_q  <= '0;
      reps_q <= '0;
    end else if (load) begin
      vec_q  <= bus.vec_in;
      reps_q <= bus.reps;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)              rep_q <= '0;
    else if (load || abort) rep_q <= '0;
    else if (hs)            rep_q <= step_rep ? rep_q + 1'b1 : '0;
  end

  // idx saturates at the last lane; only load/flush/reset rewind it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                               idx_q <= '0;
    else if (load || abort)                  idx_q <= '0;
    else if (hs && !step_rep && !last_q)     idx_q <= idx_nx;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else if (load) begin
      out_q   <= {PE_COUNT{bus.vec_in[0]}};
      valid_q <= 1'b1;
      first_q <= 1'b1;
      last_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else if (abort) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else if (done) begin
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else if (hs) begin
      if (step_rep) begin
        first_q <= 1'b0;
        last_q  <= (idx_q == IDX_MAX) &&
                   ((rep_q + 1'b1) == reps_q);
      end else begin
        out_q   <= {PE_COUNT{vec_q[idx_nx]}};
        first_q <= 1'b1;
        last_q  <= (idx_nx == IDX_MAX) &&
                   (reps_q == '0);
      end
    end
  end

  assign bus.vec_ready   = !busy_q;
  assign bus.bcast_out   = out_q;
  assign bus.bcast_valid = valid_q;
  assign bus.bcast_idx   = idx_q;
  assign bus.bcast_first = first_q;
  assign bus.bcast_last  = last_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_vec_broadcast.sv
// Scoreboard bench for vec_broadcast: stimulus pushes expected beats,
// a negedge monitor pops and compares on every presented beat.
module tb_vec_broadcast;
  import simd_pkg::*;

  localparam int PE = 4;
  localparam int DW = 32;
  localparam int RW = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  vec_broadcast_if #(
    .PE_COUNT(PE), .DATA_WIDTH(DW), .REP_W(RW)
  ) bus ();

  vec_broadcast #(
    .PE_COUNT(PE), .DATA_WIDTH(DW), .REP_W(RW)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    logic [DW-1:0] d;
    int            idx;
    bit            first;
    bit            last;
  } beat_t;

  beat_t expq[$];
  int    errors = 0;
  int    checks = 0;
  int    ready_mode = 0;
  int    pat_i = 0;
  bit    pend_last = 0;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // reference: element i sent r+1 times, lanes replicated
  task automatic push_vec(input vec_t v, input int r);
    for (int i = 0; i < PE; i++)
      for (int k = 0; k <= r; k++) begin
        beat_t b;
        b.d     = v[i];
        b.idx   = i;
        b.first = (k == 0);
        b.last  = (i == PE - 1) && (k == r);
        expq.push_back(b);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input vec_t v, input int r);
    int n = 0;
    while (!bus.vec_ready && n < 400) begin
      tick();
      n++;
    end
    chk("load_ready", bus.vec_ready, 1);
    bus.vec_in    = v;
    bus.reps      = RW'(r);
    bus.vec_valid = 1'b1;
    push_vec(v, r);
    tick();
    bus.vec_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((expq.size() != 0 || !bus.vec_ready) && n < 400) begin
      tick();
      n++;
    end
    chk("drain", (expq.size() == 0) && bus.vec_ready, 1);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_valid"}, bus.bcast_valid, 0);
    chk({nm, "_out"},   bus.bcast_out, 0);
    chk({nm, "_idx"},   bus.bcast_idx, 0);
    chk({nm, "_first"}, bus.bcast_first, 0);
    chk({nm, "_last"},  bus.bcast_last, 0);
    chk({nm, "_busy"},  bus.busy, 0);
    chk({nm, "_vrdy"},  bus.vec_ready, 1);
  endtask

  // consumer ready: always, 1-0-0 pattern, or random
  initial begin
    bus.bcast_ready = 1'b0;
    forever begin
      tick();
      case (ready_mode)
        1: begin
          bus.bcast_ready = (pat_i % 3 == 0);
          pat_i++;
        end
        2:       bus.bcast_ready = 1'($urandom_range(0, 1));
        default: bus.bcast_ready = 1'b1;
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rstn) begin
        pend_last = 0;
      end else begin
        if (pend_last) begin
          chk("post_last_valid", bus.bcast_valid, 0);
          chk("post_last_vrdy", bus.vec_ready, 1);
        end
        pend_last = 0;
        if (bus.bcast_valid) begin
          chk("beat_expected", expq.size() != 0, 1);
          if (expq.size() != 0) begin
            beat_t e;
            e = expq[0];
            chk("data",  bus.bcast_out, {PE{e.d}});
            chk("idx",   bus.bcast_idx, e.idx);
            chk("first", bus.bcast_first, e.first);
            chk("last",  bus.bcast_last, e.last);
            chk("busy",  bus.busy, 1);
            if (bus.bcast_ready && !bus.flush) begin
              void'(expq.pop_front());
              pend_last = e.last;
            end
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v, v2, va, vb;
    vec_t vs [3];
    int   rs [3];
    int   n;

    bus.vec_in    = '0;
    bus.vec_valid = 1'b0;
    bus.reps      = '0;
    bus.flush     = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    #2 rstn = 1'b1;
    tick();

    v[3] = 40;
    v[2] = -3;
    v[1] = 7;
    v[0] = 1;

    ready_mode = 0;
    load(v, 0);
    wait_idle();

    load(v, 2);
    wait_idle();

    ready_mode = 1;
    load(v, 0);
    wait_idle();
    ready_mode = 0;
    tick();

    // flush in IDLE is a no-op
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("idle_flush_valid", bus.bcast_valid, 0);
    chk("idle_flush_vrdy", bus.vec_ready, 1);

    // flush coincident with the beat-2 handshake
    load(v, 0);
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    expq.delete();
    chk("flush_valid", bus.bcast_valid, 0);
    chk("flush_vrdy",  bus.vec_ready, 1);
    chk("flush_idx",   bus.bcast_idx, 0);
    chk("flush_first", bus.bcast_first, 0);
    chk("flush_last",  bus.bcast_last, 0);
    v2    = '0;
    v2[0] = 5;
    load(v2, 0);
    wait_idle();

    // async reset during beat 3
    load(v, 0);
    tick();
    tick();
    #2 rstn = 1'b0;
    #1;
    chk_reset_vals("midrst");
    expq.delete();
    @(negedge clk);
    #2 rstn = 1'b1;
    tick();
    chk_reset_vals("postrst");

    // vec_valid pulsed while streaming must be ignored
    for (int i = 0; i < PE; i++) begin
      va[i] = $urandom;
      vb[i] = $urandom;
    end
    load(va, 1);
    tick();
    bus.vec_in    = vb;
    bus.vec_valid = 1'b1;
    tick();
    bus.vec_valid = 1'b0;
    wait_idle();
    repeat (20) tick();
    chk("ignored_load", bus.bcast_valid, 0);

    // back-to-back loads with vec_valid held
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < PE; i++) vs[j][i] = $urandom;
      rs[j] = $urandom_range(0, 2);
    end
    bus.vec_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      n = 0;
      while (!bus.vec_ready && n < 400) begin
        tick();
        n++;
      end
      chk("b2b_ready", bus.vec_ready, 1);
      if (j > 0) chk("b2b_gap", bus.bcast_valid, 0);
      bus.vec_in = vs[j];
      bus.reps   = RW'(rs[j]);
      push_vec(vs[j], rs[j]);
      tick();
      chk("b2b_valid", bus.bcast_valid, 1);
      chk("b2b_first", bus.bcast_first, 1);
    end
    bus.vec_valid = 1'b0;
    wait_idle();

    // randomized vectors, reps and consumer stalls
    ready_mode = 2;
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < PE; i++) v[i] = $urandom;
      load(v, $urandom_range(0, 3));
    end
    wait_idle();
    ready_mode = 0;
    repeat (5) tick();

    chk("queue_empty", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
